// File: rtl/slave_rx_fifo.sv
// slave_rx_fifo: FWFT receive FIFO between an upstream and a downstream valid/ready port, with a beat counter and an optional sequence checker
//   clk, rst_n          clock and synchronous active-low reset
//   data/valid/ready    upstream port; ready is high while the FIFO is not full
//   out_data/out_valid  downstream port, showing the head of the FIFO; out_valid is high while the FIFO is not empty
//   out_ready           downstream ready
//   level               occupancy, 0..DEPTH
//   xfer_cnt            number of accepted upstream beats, wraps
//   seq_err, err_cnt    sequence-break pulse and saturating count; both are 0 unless SEQ_CHECK_EN is defined
module slave_rx_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              seq_err,
  output logic [15:0]       err_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign ready     = level != (ADDR_W+1)'(DEPTH);
  assign out_valid = level != '0;
  assign out_data  = mem[rd_ptr];
  assign push      = valid & ready;
  assign pop       = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      xfer_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push) xfer_cnt <= xfer_cnt + CNT_W'(1);
      level <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push && rst_n) mem[wr_ptr] <= data;
`ifdef SEQ_CHECK_EN
  logic [DATA_W-1:0] last;
  logic has_base, bad;
  // The first beat after reset only sets the baseline and is never flagged
  assign bad = push & has_base & (data != last + DATA_W'(1));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      has_base <= 1'b0;
      seq_err  <= 1'b0;
      err_cnt  <= '0;
      last     <= '0;
    end else begin
      seq_err <= bad;
      if (bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (push) begin
        last     <= data;
        has_base <= 1'b1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_slave_rx_fifo.sv
// tb_slave_rx_fifo: directed self-checking bench for slave_rx_fifo
module tb_slave_rx_fifo;
  logic        clk = 1'b0;
  logic        rst_n, valid, out_ready, ready, out_valid, seq_err;
  logic [31:0] data, out_data, xfer_cnt;
  logic [3:0]  level;
  logic [15:0] err_cnt;
  int checks = 0, failures = 0;
`ifdef SEQ_CHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif
  always #5 clk = ~clk;
  slave_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .xfer_cnt(xfer_cnt), .seq_err(seq_err), .err_cnt(err_cnt)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reset_dut;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    logic [31:0] exp6 [3];
    int e;
    exp6[0] = 32'd10;
    exp6[1] = 32'd20;
    exp6[2] = 32'd30;
    rst_n = 1'b0; valid = 1'b0; out_ready = 1'b0; data = '0;
    tick(); tick();
    chk("rst_level", level, 0);
    chk("rst_ready", ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      data = 32'(i);
      tick();
    end
    chk("fill_level", level, 8);
    chk("fill_ready", ready, 0);
    chk("fill_xfer_cnt", xfer_cnt, 8);
    chk("fill_head", out_data, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 32'(k));
      tick();
      if (k == 1) begin
        chk("drain_ready_after_pop", ready, 1);
        chk("drain_level_after_pop", level, 7);
      end
      if (k == 2) begin
        valid = 1'b0;
        chk("drain_beat9_taken", xfer_cnt, 9);
      end
    end
    chk("drain_level", level, 0);
    chk("drain_out_valid", out_valid, 0);
    out_ready = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data = 32'(100 + i);
      tick();
    end
    chk("conc_pre_level", level, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = 32'(104 + i);
      chk("conc_data", out_data, 32'(100 + i));
      tick();
      chk("conc_level", level, 4);
    end
    chk("conc_xfer_cnt", xfer_cnt, 23);
    out_ready = 1'b0;
    data = 32'd114;
    tick();
    chk("midrst_pre_level", level, 5);
    rst_n = 1'b0;
    data = 32'h55;
    tick();
    rst_n = 1'b1;
    valid = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_xfer_cnt", xfer_cnt, 0);
    valid = 1'b1;
    data = 32'h77;
    tick();
    valid = 1'b0;
    chk("midrst_first_valid", out_valid, 1);
    chk("midrst_first_data", out_data, 32'h77);
    chk("midrst_first_level", level, 1);
    chk("midrst_first_xfer", xfer_cnt, 1);
    reset_dut();
    out_ready = 1'b1;
    valid = 1'b1;
    data = 32'd5; tick();
    chk("seq_5_err", seq_err, 0);
    chk("seq_5_fwd", out_data, 5);
    data = 32'd6; tick();
    chk("seq_6_err", seq_err, 0);
    chk("seq_6_fwd", out_data, 6);
    data = 32'd8; tick();
    chk("seq_8_err", seq_err, SC);
    chk("seq_8_fwd", out_data, 8);
    data = 32'd9; tick();
    chk("seq_9_err", seq_err, 0);
    chk("seq_9_fwd", out_data, 9);
    chk("seq_err_cnt", err_cnt, 64'(SC));
    valid = 1'b0;
    tick();
    chk("seq_drained", out_valid, 0);
    reset_dut();
    valid = 1'b1;
    data = 32'hFFFF_FFFF; tick();
    data = 32'h0; tick();
    valid = 1'b0;
    chk("wrap_err", seq_err, 0);
    chk("wrap_fwd", out_data, 0);
    tick();
    chk("wrap_err_cnt", err_cnt, 0);
    chk("wrap_drained", level, 0);
    reset_dut();
    out_ready = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = exp6[i];
      tick();
    end
    valid = 1'b0;
    e = 0;
    for (int c = 0; c < 6; c++) begin
      out_ready = c[0];
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, exp6[e]);
      tick();
      if (out_ready) e++;
      else chk("bp_hold", out_data, exp6[e]);
    end
    chk("bp_level", level, 0);
    chk("bp_xfer_cnt", xfer_cnt, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
